// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor:
//     DEFAULT_WIDTH - default operand/result width
//     state_t       - controller state encoding (ST_IDLE/ST_SHIFT/ST_DONE)
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   One-bit combinational subtractor: din_A - din_B - din_bin.
//   Ports:
//     din_A       - minuend bit
//     din_B       - subtrahend bit
//     din_bin     - borrow in
//     dout_diff   - difference bit
//     dout_borrow - borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic din_A,
  input  logic din_B,
  input  logic din_bin,
  output logic dout_diff,
  output logic dout_borrow
);

  always_comb begin
    dout_diff   = din_A ^ din_B ^ din_bin;
    dout_borrow = (~din_A & din_B) | (~(din_A ^ din_B) & din_bin);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor, LSB first, one bit per clock.
//   An operation takes WIDTH cycles in SHIFT followed by one DONE cycle.
//   Optional feature: define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the
//   dout_overflow port (signed two's-complement overflow of A - B).
//   Ports:
//     clk           - clock, rising edge
//     rst           - synchronous active-high reset
//     din_start     - start request (ignored while busy)
//     din_A, din_B  - minuend / subtrahend, captured on an accepted start
//     dout_busy     - high while in SHIFT
//     dout_done     - one-cycle pulse in DONE
//     dout_diff     - (A - B) mod 2^WIDTH, updated on entry to DONE
//     dout_borrow   - borrow out (A < B), updated on entry to DONE
//     dout_overflow - signed overflow (only with SERIAL_SUBTRACTOR_OVERFLOW_EN)
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_start,
  input  logic [WIDTH-1:0] din_A,
  input  logic [WIDTH-1:0] din_B,
  output logic             dout_busy,
  output logic             dout_done,
  output logic [WIDTH-1:0] dout_diff,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  output logic             dout_borrow,
  output logic             dout_overflow
`else
  output logic             dout_borrow
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] result_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             fs_diff;
  logic             fs_borrow;
  logic             accept;
  logic             last_bit;

  assign accept   = din_start && (state != ST_SHIFT);
  assign last_bit = (state == ST_SHIFT) && (cnt == CW'(WIDTH - 1));

  full_subtractor u_full_subtractor (
    .din_A       (shift_a[0]),
    .din_B       (shift_b[0]),
    .din_bin     (borrow),
    .dout_diff   (fs_diff),
    .dout_borrow (fs_borrow)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (din_start) next_state = ST_SHIFT;
      ST_SHIFT: if (last_bit)  next_state = ST_DONE;
      ST_DONE:  next_state = din_start ? ST_SHIFT : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    dout_busy = (state == ST_SHIFT);
    dout_done = (state == ST_DONE);
  end

  // Datapath: operand shifters, borrow flop, bit counter, result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_a       <= '0;
      shift_b       <= '0;
      result_sr     <= '0;
      cnt           <= '0;
      borrow        <= 1'b0;
      dout_diff     <= '0;
      dout_borrow   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      dout_overflow <= 1'b0;
`endif
    end else if (accept) begin
      shift_a   <= din_A;
      shift_b   <= din_B;
      result_sr <= '0;
      cnt       <= '0;
      borrow    <= 1'b0;
    end else if (state == ST_SHIFT) begin
      shift_a   <= {1'b0, shift_a[WIDTH-1:1]};
      shift_b   <= {1'b0, shift_b[WIDTH-1:1]};
      result_sr <= {fs_diff, result_sr[WIDTH-1:1]};
      cnt       <= cnt + 1'b1;
      borrow    <= fs_borrow;
      // Publish the finished word directly from the last bit so the visible
      // result changes only on entry to DONE.
      if (last_bit) begin
        dout_diff   <= {fs_diff, result_sr[WIDTH-1:1]};
        dout_borrow <= fs_borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        // On the last bit the shifters hold the operand MSBs at bit 0.
        dout_overflow <= (shift_a[0] ^ shift_b[0]) & (fs_diff ^ shift_a[0]);
`endif
      end
    end
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8). Expected results come
//   from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         din_start = 1'b0;
  logic [W-1:0] din_A = '0;
  logic [W-1:0] din_B = '0;
  logic         dout_busy;
  logic         dout_done;
  logic [W-1:0] dout_diff;
  logic         dout_borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic         dout_overflow;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din_start   (din_start),
    .din_A       (din_A),
    .din_B       (din_B),
    .dout_busy   (dout_busy),
    .dout_done   (dout_done),
    .dout_diff   (dout_diff),
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    .dout_borrow (dout_borrow),
    .dout_overflow (dout_overflow)
`else
    .dout_borrow (dout_borrow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    int d;
    d = (int'(a) - int'(b) + 256) % 256;
    return W'(d);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
    return int'(a) < int'(b);
  endfunction

  function automatic logic ref_overflow(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, sd;
    sa = $signed(a);
    sb = $signed(b);
    sd = sa - sb;
    return (sd < -128) || (sd > 127);
  endfunction

  // Issues a start from a negedge and follows the operation to its done pulse.
  // edges = posedges after the accepting edge until done is seen (-1: timeout).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int edges, output int busy_cnt, output logic held_ok);
    logic [W-1:0] d0;
    logic         b0;
    int           n;
    din_A = a;
    din_B = b;
    din_start = 1'b1;
    @(posedge clk);
    #1;
    din_start = 1'b0;
    din_A = W'($urandom);
    din_B = W'($urandom);
    edges = -1;
    busy_cnt = 0;
    held_ok = 1'b1;
    n = 0;
    @(negedge clk);
    d0 = dout_diff;
    b0 = dout_borrow;
    while (n < 40) begin
      if (dout_done) begin
        edges = n;
        break;
      end
      if (dout_busy) busy_cnt++;
      if (dout_diff !== d0 || dout_borrow !== b0) held_ok = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din_start = 1'b1;
    din_A = 8'd200;
    din_B = 8'd55;
    repeat (3) @(negedge clk);
    checks++; if (dout_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", dout_busy); end
    checks++; if (dout_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", dout_done); end
    checks++; if (dout_diff !== 8'd0) begin errors++; $display("FAIL reset_diff: got %0d expected 0", dout_diff); end
    checks++; if (dout_borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b expected 0", dout_borrow); end
    rst = 1'b0;
    din_start = 1'b0;
    @(negedge clk);
    checks++; if (dout_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after: got busy=%b expected 0", dout_busy); end
  endtask

  task automatic test_basic();
    int   edges, busy_cnt;
    logic held;
    do_op(8'd200, 8'd55, edges, busy_cnt, held);
    // done appears W edges after the accepting edge (the W+1-th edge counting it)
    checks++; if (edges !== W) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", edges, W); end
    checks++; if (busy_cnt !== W) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", busy_cnt, W); end
    checks++; if (!held) begin errors++; $display("FAIL basic_no_partial: got changed expected held"); end
    checks++; if (dout_diff !== 8'd145) begin errors++; $display("FAIL basic_diff: got %0d expected 145", dout_diff); end
    checks++; if (dout_borrow !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b expected 0", dout_borrow); end
    @(negedge clk);
    checks++; if (dout_done !== 1'b0 || dout_busy !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle: got done=%b busy=%b expected 0 0", dout_done, dout_busy); end
    checks++; if (dout_diff !== 8'd145) begin errors++; $display("FAIL basic_hold: got %0d expected 145", dout_diff); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{8'd5, 8'd0, 8'd0};
    logic [W-1:0] vb [3] = '{8'd9, 8'd1, 8'd0};
    logic [W-1:0] ed [3] = '{8'd252, 8'd255, 8'd0};
    logic         eb [3] = '{1'b1, 1'b1, 1'b0};
    int   edges, busy_cnt;
    logic held;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      do_op(va[i], vb[i], edges, busy_cnt, held);
      checks++; if (edges !== W) begin errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, edges, W); end
      checks++; if (dout_diff !== ed[i]) begin errors++; $display("FAIL vec%0d_diff: got %0d expected %0d", i, dout_diff, ed[i]); end
      checks++; if (dout_borrow !== eb[i]) begin errors++; $display("FAIL vec%0d_borrow: got %b expected %b", i, dout_borrow, eb[i]); end
    end
  endtask

  task automatic test_ignore_start();
    int           pulses;
    logic [W-1:0] got;
    logic         gb;
    @(negedge clk);
    din_A = 8'd10;
    din_B = 8'd3;
    din_start = 1'b1;
    @(posedge clk);
    #1;
    din_start = 1'b0;
    pulses = 0;
    got = '0;
    gb = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (dout_done) begin
        pulses++;
        got = dout_diff;
        gb = dout_borrow;
      end
      din_start = (c >= 2 && c <= 5);
      din_A = 8'd99;
      din_B = W'($urandom);
    end
    din_start = 1'b0;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
    checks++; if (got !== 8'd7) begin errors++; $display("FAIL ignore_diff: got %0d expected 7", got); end
    checks++; if (gb !== 1'b0) begin errors++; $display("FAIL ignore_borrow: got %b expected 0", gb); end
  endtask

  task automatic test_back_to_back();
    int   edges, busy_cnt;
    logic held;
    @(negedge clk);
    do_op(8'd50, 8'd20, edges, busy_cnt, held);
    checks++; if (dout_diff !== 8'd30) begin errors++; $display("FAIL b2b_first_diff: got %0d expected 30", dout_diff); end
    // Start is presented while DONE is showing: the next op must start at once.
    do_op(8'd1, 8'd2, edges, busy_cnt, held);
    checks++; if (edges !== W) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", edges, W); end
    checks++; if (busy_cnt !== W) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", busy_cnt, W); end
    checks++; if (dout_diff !== 8'd255) begin errors++; $display("FAIL b2b_diff: got %0d expected 255", dout_diff); end
    checks++; if (dout_borrow !== 1'b1) begin errors++; $display("FAIL b2b_borrow: got %b expected 1", dout_borrow); end
  endtask

  task automatic test_mid_reset();
    int   pulses;
    int   edges, busy_cnt;
    logic held;
    @(negedge clk);
    din_A = 8'd200;
    din_B = 8'd55;
    din_start = 1'b1;
    @(posedge clk);
    #1;
    din_start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (dout_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", dout_busy); end
    checks++; if (dout_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", dout_done); end
    checks++; if (dout_diff !== 8'd0 || dout_borrow !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got diff=%0d borrow=%b expected 0 0", dout_diff, dout_borrow); end
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (dout_done || dout_busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", pulses); end
    do_op(8'd77, 8'd33, edges, busy_cnt, held);
    checks++; if (edges !== W || dout_diff !== 8'd44 || dout_borrow !== 1'b0) begin errors++; $display("FAIL midrst_fresh: got edges=%0d diff=%0d borrow=%b expected %0d 44 0", edges, dout_diff, dout_borrow, W); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    int   edges, busy_cnt;
    logic held;
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      do_op(a, b, edges, busy_cnt, held);
      checks++;
      if (edges !== W || dout_diff !== ref_diff(a, b) || dout_borrow !== ref_borrow(a, b)) begin
        errors++;
        $display("FAIL rand%0d a=%0d b=%0d: got edges=%0d diff=%0d borrow=%b expected %0d %0d %b",
                 i, a, b, edges, dout_diff, dout_borrow, W, ref_diff(a, b), ref_borrow(a, b));
      end
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      checks++;
      if (dout_overflow !== ref_overflow(a, b)) begin
        errors++;
        $display("FAIL rand%0d_ovf a=%0d b=%0d: got %b expected %b", i, a, b, dout_overflow, ref_overflow(a, b));
      end
`endif
    end
  endtask

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  task automatic test_overflow();
    int   edges, busy_cnt;
    logic held;
    @(negedge clk);
    do_op(8'h80, 8'h01, edges, busy_cnt, held);
    checks++; if (dout_diff !== 8'h7F || dout_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got diff=%h ovf=%b expected 7f 1", dout_diff, dout_overflow); end
    @(negedge clk);
    do_op(8'h10, 8'h01, edges, busy_cnt, held);
    checks++; if (dout_diff !== 8'h0F || dout_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got diff=%h ovf=%b expected 0f 0", dout_diff, dout_overflow); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h80, 8'h01, edges, busy_cnt, held);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (dout_overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset: got %b expected 0", dout_overflow); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    test_overflow();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Referenced so the overflow model is used in every build.
  logic unused_ovf_model;
  assign unused_ovf_model = ref_overflow(8'h00, 8'h00);

endmodule : tb_serial_subtractor
